// File: rtl/exec_control.sv
// ---------------------------------------------------------------------------
// exec_control
//
// Run/step/breakpoint controller for a data path. It does not switch or gate
// the clock. It produces a plain clock-enable (o_pipeline_enable) that the
// data path qualifies its own registers with.
//
// Ports
//   i_clock            single clock, all state on the rising edge
//   i_reset            asynchronous, active-high reset
//   i_cmd_valid/i_cmd  command strobe and code (00 RUN, 01 STEP, 10 STOP, 11 CLEAR)
//   i_step_count       cycles to execute for a STEP command (0 behaves as 1)
//   i_pc               current data-path PC, compared against the breakpoints
//   i_hlt              data path executed HLT this cycle
//   i_bkpt_we/idx/addr/en  breakpoint table write port
//   o_pipeline_enable  data-path clock enable (combinational, same-cycle stops)
//   o_busy             controller is in RUN or STEP
//   o_done             one-cycle pulse after entering PAUSED or HALTED
//   o_stop_cause       0 none, 1 step done, 2 breakpoint, 3 user stop, 4 hlt
//   o_bkpt_idx         index of the last breakpoint hit
//   o_cycle_count      enabled cycles since reset/CLEAR, saturating
//   o_state            one-hot {HALTED, PAUSED, STEP, RUN, IDLE}
// ---------------------------------------------------------------------------
module exec_control #(
  parameter int DWORD   = 32,
  parameter int NB_STEP = 16,
  parameter int N_BKPT  = 4,
  parameter int NB_BIDX = $clog2(N_BKPT)
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_cmd_valid,
  input  logic [1:0]         i_cmd,
  input  logic [NB_STEP-1:0] i_step_count,
  input  logic [DWORD-1:0]   i_pc,
  input  logic               i_hlt,
  input  logic               i_bkpt_we,
  input  logic [NB_BIDX-1:0] i_bkpt_idx,
  input  logic [DWORD-1:0]   i_bkpt_addr,
  input  logic               i_bkpt_en,
  output logic               o_pipeline_enable,
  output logic               o_busy,
  output logic               o_done,
  output logic [2:0]         o_stop_cause,
  output logic [NB_BIDX-1:0] o_bkpt_idx,
  output logic [DWORD-1:0]   o_cycle_count,
  output logic [4:0]         o_state
);

  // The encoding is the one-hot o_state pattern, so the register drives the
  // output directly.
  typedef enum logic [4:0] {
    S_IDLE   = 5'b00001,
    S_RUN    = 5'b00010,
    S_STEP   = 5'b00100,
    S_PAUSED = 5'b01000,
    S_HALTED = 5'b10000
  } state_t;

  typedef enum logic [1:0] {
    CMD_RUN   = 2'b00,
    CMD_STEP  = 2'b01,
    CMD_STOP  = 2'b10,
    CMD_CLEAR = 2'b11
  } cmd_t;

  typedef enum logic [2:0] {
    CAUSE_NONE = 3'd0,
    CAUSE_STEP = 3'd1,
    CAUSE_BKPT = 3'd2,
    CAUSE_USER = 3'd3,
    CAUSE_HLT  = 3'd4
  } cause_t;

  localparam logic [NB_STEP-1:0] STEP_ONE = NB_STEP'(1);
  localparam logic [DWORD-1:0]   CNT_MAX  = '1;

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  state_t               state;
  logic [NB_STEP-1:0]   step_cnt;
  logic                 first_cycle;   // first cycle after entering RUN/STEP
  logic                 done_q;
  cause_t               cause_q;
  logic [NB_BIDX-1:0]   bidx_q;
  logic [DWORD-1:0]     count_q;

  logic [DWORD-1:0]     bkpt_addr [N_BKPT];
  logic [N_BKPT-1:0]    bkpt_en;

  // -------------------------------------------------------------------------
  // Command decode
  // -------------------------------------------------------------------------
  cmd_t cmd;
  logic cmd_run, cmd_step, cmd_stop, cmd_clear;

  assign cmd       = cmd_t'(i_cmd);
  assign cmd_run   = i_cmd_valid && (cmd == CMD_RUN);
  assign cmd_step  = i_cmd_valid && (cmd == CMD_STEP);
  assign cmd_stop  = i_cmd_valid && (cmd == CMD_STOP);
  assign cmd_clear = i_cmd_valid && (cmd == CMD_CLEAR);

  // -------------------------------------------------------------------------
  // Breakpoint compare: lowest enabled matching entry wins. The table is read
  // as currently registered, so a write this cycle only affects the next one.
  // -------------------------------------------------------------------------
  logic               hit_any;
  logic [NB_BIDX-1:0] hit_idx;

  always_comb begin
    // NOTE: every variable written in a combinational block gets a default
    // first; a path that leaves one unassigned would infer a latch.
    hit_any = 1'b0;
    hit_idx = '0;
    // Scan downwards so the last assignment is the lowest matching index.
    for (int i = N_BKPT - 1; i >= 0; i--) begin
      if (bkpt_en[i] && (bkpt_addr[i] == i_pc)) begin
        hit_any = 1'b1;
        hit_idx = NB_BIDX'(i);
      end
    end
  end

  // -------------------------------------------------------------------------
  // Same-cycle stop conditions, listed in priority order. Each one holds the
  // pipeline enable low in the cycle it occurs.
  // -------------------------------------------------------------------------
  logic busy_state;
  logic stop_hlt, stop_bkpt, stop_user, stop_any;
  logic step_last;

  assign busy_state = (state == S_RUN) || (state == S_STEP);
  assign stop_hlt   = busy_state && i_hlt;
  // Masking the first cycle lets a resume from a breakpoint PC move on.
  assign stop_bkpt  = busy_state && hit_any && !first_cycle;
  assign stop_user  = busy_state && cmd_stop;
  assign stop_any   = stop_hlt || stop_bkpt || stop_user;

  assign o_pipeline_enable = busy_state && !stop_any;

  // The step counter is never below 1 while in STEP. The <= comparison only
  // guards against an illegal value.
  assign step_last = (state == S_STEP) && o_pipeline_enable && (step_cnt <= STEP_ONE);

  // -------------------------------------------------------------------------
  // Breakpoint table
  // -------------------------------------------------------------------------
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      // NOTE: this table is small and must come up with every entry disabled,
      // so it is a resettable register array rather than a RAM.
      for (int i = 0; i < N_BKPT; i++) begin
        bkpt_addr[i] <= '0;
      end
      bkpt_en <= '0;
    end else if (i_bkpt_we) begin
      bkpt_addr[i_bkpt_idx] <= i_bkpt_addr;
      bkpt_en[i_bkpt_idx]   <= i_bkpt_en;
    end
  end

  // -------------------------------------------------------------------------
  // Control FSM with registered status outputs
  // -------------------------------------------------------------------------
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      // NOTE: state uses non-blocking assignments only, so every register
      // here samples values from before the edge.
      state       <= S_IDLE;
      step_cnt    <= '0;
      first_cycle <= 1'b0;
      done_q      <= 1'b0;
      cause_q     <= CAUSE_NONE;
      bidx_q      <= '0;
      count_q     <= '0;
    end else begin
      done_q <= 1'b0;

      if (o_pipeline_enable && (count_q != CNT_MAX)) begin
        count_q <= count_q + DWORD'(1);
      end

      unique case (state)
        S_IDLE, S_PAUSED: begin
          if (cmd_run) begin
            state       <= S_RUN;
            first_cycle <= 1'b1;
            cause_q     <= CAUSE_NONE;
          end else if (cmd_step) begin
            state       <= S_STEP;
            first_cycle <= 1'b1;
            cause_q     <= CAUSE_NONE;
            step_cnt    <= (i_step_count == '0) ? STEP_ONE : i_step_count;
          end else if (cmd_clear) begin
            state   <= S_IDLE;
            count_q <= '0;
            cause_q <= CAUSE_NONE;
            bidx_q  <= '0;
          end
        end

        S_RUN, S_STEP: begin
          first_cycle <= 1'b0;
          if (stop_hlt) begin
            state   <= S_HALTED;
            cause_q <= CAUSE_HLT;
            done_q  <= 1'b1;
          end else if (stop_bkpt) begin
            state   <= S_PAUSED;
            cause_q <= CAUSE_BKPT;
            bidx_q  <= hit_idx;
            done_q  <= 1'b1;
          end else if (stop_user) begin
            state   <= S_PAUSED;
            cause_q <= CAUSE_USER;
            done_q  <= 1'b1;
          end else if (step_last) begin
            state   <= S_PAUSED;
            cause_q <= CAUSE_STEP;
            done_q  <= 1'b1;
          end

          if ((state == S_STEP) && o_pipeline_enable) begin
            step_cnt <= step_cnt - STEP_ONE;
          end
        end

        S_HALTED: begin
          // Sticky: only CLEAR leaves HALTED.
          if (cmd_clear) begin
            state   <= S_IDLE;
            count_q <= '0;
            cause_q <= CAUSE_NONE;
            bidx_q  <= '0;
          end
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign o_state       = state;
  assign o_busy        = o_state[1] | o_state[2];
  assign o_done        = done_q;
  assign o_stop_cause  = cause_q;
  assign o_bkpt_idx    = bidx_q;
  assign o_cycle_count = count_q;

endmodule

// File: tb/tb_exec_control.sv
// ---------------------------------------------------------------------------
// tb_exec_control
//
// Self-checking bench for exec_control. A behavioural model tracks the mode,
// the remaining step budget, the breakpoint list and the saturating counter.
// Every cycle, the outputs of the default-parameter instance are compared
// against that model. A second instance with DWORD=4 exercises counter
// saturation.
// ---------------------------------------------------------------------------
module tb_exec_control;

  localparam logic [1:0] C_RUN = 2'd0, C_STEP = 2'd1, C_STOP = 2'd2, C_CLEAR = 2'd3;
  localparam int M_IDLE = 0, M_RUN = 1, M_STEP = 2, M_PAUSED = 3, M_HALTED = 4;
  localparam longint CNT_MAX = 64'hFFFF_FFFF;

  logic        i_clock = 1'b0;
  logic        i_reset = 1'b1;
  logic        i_cmd_valid = 1'b0;
  logic [1:0]  i_cmd = 2'd0;
  logic [15:0] i_step_count = '0;
  logic [31:0] i_pc = '0;
  logic        i_hlt = 1'b0;
  logic        i_bkpt_we = 1'b0;
  logic [1:0]  i_bkpt_idx = '0;
  logic [31:0] i_bkpt_addr = '0;
  logic        i_bkpt_en = 1'b0;
  logic        o_pipeline_enable, o_busy, o_done;
  logic [2:0]  o_stop_cause;
  logic [1:0]  o_bkpt_idx;
  logic [31:0] o_cycle_count;
  logic [4:0]  o_state;

  // Small-counter instance signals
  logic        s_cmd_valid = 1'b0;
  logic [1:0]  s_cmd = 2'd0;
  logic        s_pipeline_enable, s_busy, s_done;
  logic [2:0]  s_stop_cause;
  logic [1:0]  s_bkpt_idx;
  logic [3:0]  s_cycle_count;
  logic [4:0]  s_state;

  always #5 i_clock = ~i_clock;

  exec_control dut (
    .i_clock(i_clock), .i_reset(i_reset), .i_cmd_valid(i_cmd_valid), .i_cmd(i_cmd),
    .i_step_count(i_step_count), .i_pc(i_pc), .i_hlt(i_hlt), .i_bkpt_we(i_bkpt_we),
    .i_bkpt_idx(i_bkpt_idx), .i_bkpt_addr(i_bkpt_addr), .i_bkpt_en(i_bkpt_en),
    .o_pipeline_enable(o_pipeline_enable), .o_busy(o_busy), .o_done(o_done),
    .o_stop_cause(o_stop_cause), .o_bkpt_idx(o_bkpt_idx), .o_cycle_count(o_cycle_count),
    .o_state(o_state)
  );

  exec_control #(.DWORD(4)) dut4 (
    .i_clock(i_clock), .i_reset(i_reset), .i_cmd_valid(s_cmd_valid), .i_cmd(s_cmd),
    .i_step_count(16'd0), .i_pc(4'd0), .i_hlt(1'b0), .i_bkpt_we(1'b0),
    .i_bkpt_idx(2'd0), .i_bkpt_addr(4'd0), .i_bkpt_en(1'b0),
    .o_pipeline_enable(s_pipeline_enable), .o_busy(s_busy), .o_done(s_done),
    .o_stop_cause(s_stop_cause), .o_bkpt_idx(s_bkpt_idx), .o_cycle_count(s_cycle_count),
    .o_state(s_state)
  );

  // -------------------------------------------------------------------------
  // Checking
  // -------------------------------------------------------------------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
  endtask

  // -------------------------------------------------------------------------
  // Reference model
  // -------------------------------------------------------------------------
  int          m_mode;
  int          m_left;       // steps still allowed in STEP mode
  bit          m_fresh;      // just started running: breakpoints ignored
  longint      m_count;
  int          m_cause;
  int          m_bidx;
  bit          m_done;
  logic [31:0] bp_addr [4];
  bit          bp_on   [4];

  int m_hit;
  bit e_hlt, e_bp, e_usr, e_en;

  task automatic model_reset();
    m_mode = M_IDLE; m_left = 0; m_fresh = 0; m_count = 0;
    m_cause = 0; m_bidx = 0; m_done = 0;
    for (int i = 0; i < 4; i++) begin bp_addr[i] = '0; bp_on[i] = 0; end
  endtask

  task automatic model_eval();
    bit running;
    running = (m_mode == M_RUN) || (m_mode == M_STEP);
    m_hit = -1;
    for (int i = 0; i < 4; i++)
      if (m_hit < 0 && bp_on[i] && bp_addr[i] == i_pc) m_hit = i;
    e_hlt = running && i_hlt;
    e_bp  = running && !m_fresh && (m_hit >= 0);
    e_usr = running && i_cmd_valid && (i_cmd == C_STOP);
    e_en  = running && !(e_hlt || e_bp || e_usr);
  endtask

  task automatic model_advance();
    m_done = 0;
    if (e_en && m_count < CNT_MAX) m_count++;
    case (m_mode)
      M_IDLE, M_PAUSED: if (i_cmd_valid) begin
        case (i_cmd)
          C_RUN:   begin m_mode = M_RUN; m_fresh = 1; m_cause = 0; end
          C_STEP:  begin
                     m_mode = M_STEP; m_fresh = 1; m_cause = 0;
                     m_left = (i_step_count == 0) ? 1 : int'(i_step_count);
                   end
          C_CLEAR: begin m_mode = M_IDLE; m_count = 0; m_cause = 0; m_bidx = 0; end
          default: ;
        endcase
      end
      M_RUN, M_STEP: begin
        m_fresh = 0;
        if (e_hlt)      begin m_mode = M_HALTED; m_cause = 4; m_done = 1; end
        else if (e_bp)  begin m_mode = M_PAUSED; m_cause = 2; m_bidx = m_hit; m_done = 1; end
        else if (e_usr) begin m_mode = M_PAUSED; m_cause = 3; m_done = 1; end
        else if (m_mode == M_STEP) begin
          m_left--;
          if (m_left == 0) begin m_mode = M_PAUSED; m_cause = 1; m_done = 1; end
        end
      end
      default: if (i_cmd_valid && i_cmd == C_CLEAR) begin
        m_mode = M_IDLE; m_count = 0; m_cause = 0; m_bidx = 0;
      end
    endcase
    if (i_bkpt_we) begin
      bp_addr[i_bkpt_idx] = i_bkpt_addr;
      bp_on[i_bkpt_idx]   = i_bkpt_en;
    end
  endtask

  // -------------------------------------------------------------------------
  // One clock: inputs are already applied at posedge+1. Compare at posedge+4,
  // advance the model, then return at the next posedge+1.
  // -------------------------------------------------------------------------
  int en_cnt  = 0;
  bit last_en = 0;

  task automatic tick();
    #3;
    model_eval();
    last_en = o_pipeline_enable;
    if (o_pipeline_enable) en_cnt++;
    check("enable", o_pipeline_enable, e_en);
    check("state", o_state, 64'(1) << m_mode);
    check("busy", o_busy, (m_mode == M_RUN || m_mode == M_STEP));
    check("done", o_done, m_done);
    check("cause", o_stop_cause, m_cause);
    check("bkpt_idx", o_bkpt_idx, m_bidx);
    check("count", o_cycle_count, m_count);
    model_advance();
    @(posedge i_clock);
    #1;
  endtask

  task automatic idle_inputs();
    i_cmd_valid = 0; i_hlt = 0; i_bkpt_we = 0;
  endtask

  task automatic send(input logic [1:0] c, input logic [15:0] sc);
    i_cmd_valid = 1; i_cmd = c; i_step_count = sc;
    tick();
    idle_inputs();
  endtask

  task automatic run_until_done(input int budget);
    int n = 0;
    while (n < budget) begin
      tick();
      n++;
      if (o_done) break;
    end
    check("done_timeout", o_done, 1);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_state"}, o_state, 5'b00001);
    check({tag, "_enable"}, o_pipeline_enable, 0);
    check({tag, "_busy"}, o_busy, 0);
    check({tag, "_done"}, o_done, 0);
    check({tag, "_cause"}, o_stop_cause, 0);
    check({tag, "_bidx"}, o_bkpt_idx, 0);
    check({tag, "_count"}, o_cycle_count, 0);
  endtask

  logic [31:0] pcs [5];

  initial begin
    pcs[0] = 32'h10; pcs[1] = 32'h40; pcs[2] = 32'h50; pcs[3] = 32'h60; pcs[4] = 32'h100;
    model_reset();
    #12;
    check_reset_values("por");
    i_reset = 0;
    @(posedge i_clock); #1;

    // Counter saturation on the 4-bit instance
    s_cmd_valid = 1; s_cmd = C_RUN;
    @(posedge i_clock); #1;
    s_cmd_valid = 0;
    for (int j = 0; j < 20; j++) begin
      #3;
      check("sat_enable", s_pipeline_enable, 1);
      check("sat_count", s_cycle_count, (j < 15) ? j : 15);
      @(posedge i_clock); #1;
    end
    check("sat_final", s_cycle_count, 4'hF);

    // STEP 3 from IDLE
    i_pc = 32'h100;
    en_cnt = 0;
    send(C_STEP, 16'd3);
    run_until_done(10);
    check("step3_en", en_cnt, 3);
    check("step3_cause", o_stop_cause, 1);
    check("step3_state", o_state, 5'b01000);
    check("step3_count", o_cycle_count, 3);

    // Breakpoint entry 2 at 0x10
    i_bkpt_we = 1; i_bkpt_idx = 2; i_bkpt_addr = 32'h10; i_bkpt_en = 1;
    tick();
    idle_inputs();
    i_pc = 32'h0;
    send(C_RUN, 16'd0);
    for (int a = 4; a <= 16; a += 4) begin
      i_pc = 32'(a);
      tick();
    end
    check("bp_en_low", last_en, 0);
    check("bp_state", o_state, 5'b01000);
    check("bp_cause", o_stop_cause, 2);
    check("bp_idx", o_bkpt_idx, 2);
    check("bp_done", o_done, 1);
    send(C_RUN, 16'd0);
    tick();
    check("bp_resume_en", last_en, 1);
    tick();
    check("bp_rehit_en", last_en, 0);

    // HLT together with a breakpoint match
    i_bkpt_we = 1; i_bkpt_idx = 0; i_bkpt_addr = 32'h40; i_bkpt_en = 1;
    i_pc = 32'h100;
    tick();
    idle_inputs();
    send(C_RUN, 16'd0);
    tick();
    i_pc = 32'h40; i_hlt = 1;
    tick();
    i_hlt = 0;
    check("hlt_state", o_state, 5'b10000);
    check("hlt_cause", o_stop_cause, 4);
    send(C_RUN, 16'd0);
    send(C_STEP, 16'd2);
    check("hlt_sticky", o_state, 5'b10000);
    send(C_CLEAR, 16'd0);
    check("clear_state", o_state, 5'b00001);
    check("clear_count", o_cycle_count, 0);
    check("clear_cause", o_stop_cause, 0);

    // STEP 0 behaves as STEP 1, then STEP 5 cut short by STOP
    i_pc = 32'h100;
    en_cnt = 0;
    send(C_STEP, 16'd0);
    run_until_done(5);
    check("step0_en", en_cnt, 1);
    check("step0_cause", o_stop_cause, 1);
    en_cnt = 0;
    send(C_STEP, 16'd5);
    tick();
    send(C_STOP, 16'd0);
    check("stop_en", en_cnt, 1);
    check("stop_cause", o_stop_cause, 3);
    check("stop_state", o_state, 5'b01000);
    check("stop_done", o_done, 1);

    // Asynchronous reset in the middle of RUN
    send(C_RUN, 16'd0);
    tick();
    #2;
    check("pre_reset_en", o_pipeline_enable, 1);
    i_reset = 1;
    #1;
    check_reset_values("async");
    model_reset();
    #2;
    i_reset = 0;
    @(posedge i_clock); #1;

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      i_cmd_valid  = ($urandom_range(0, 9) == 0);
      i_cmd        = 2'($urandom_range(0, 3));
      i_step_count = 16'($urandom_range(0, 6));
      i_pc         = pcs[$urandom_range(0, 4)];
      i_hlt        = ($urandom_range(0, 49) == 0);
      i_bkpt_we    = ($urandom_range(0, 19) == 0);
      i_bkpt_idx   = 2'($urandom_range(0, 3));
      i_bkpt_addr  = pcs[$urandom_range(0, 4)];
      i_bkpt_en    = 1'($urandom_range(0, 1));
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/exec_control.md
EXEC_CONTROL -- requirements
Module: exec_control

Interface
REQ-001 Parameters SHALL be: DWORD, default 32, PC and cycle-counter width; NB_STEP, default 16, step-count width; N_BKPT, default 4, number of PC breakpoints (power of 2, >=2); NB_BIDX = clog2(N_BKPT).
REQ-002 Ports SHALL be (name  direction  width  meaning):
  i_clock  in  1  single clock, all state on rising edge
  i_reset  in  1  asynchronous, active-high reset
  i_cmd_valid  in  1  command strobe, sampled every cycle
  i_cmd  in  2  00 RUN, 01 STEP, 10 STOP, 11 CLEAR
  i_step_count  in  NB_STEP  cycles to execute for STEP
  i_pc  in  DWORD  current data-path PC
  i_hlt  in  1  data path executed HLT
  i_bkpt_we  in  1  breakpoint table write strobe
  i_bkpt_idx  in  NB_BIDX  entry to write
  i_bkpt_addr  in  DWORD  breakpoint PC value
  i_bkpt_en  in  1  entry enable bit written
  o_pipeline_enable  out  1  data-path clock enable
  o_busy  out  1  state is RUN or STEP
  o_done  out  1  one-cycle pulse on entering PAUSED or HALTED
  o_stop_cause  out  3  0 none, 1 step done, 2 breakpoint, 3 user stop, 4 hlt
  o_bkpt_idx  out  NB_BIDX  index of last breakpoint hit
  o_cycle_count  out  DWORD  enabled cycles since reset/CLEAR
  o_state  out  5  one-hot {HALTED,PAUSED,STEP,RUN,IDLE}, bit0 = IDLE

Function
REQ-003 Block SHALL replace clock muxing with a clock enable; o_pipeline_enable SHALL never be a gated or derived clock.
REQ-004 FSM states SHALL be IDLE, RUN, STEP, PAUSED, HALTED, one-hot on o_state.
REQ-005 IDLE/PAUSED: RUN cmd -> RUN; STEP cmd -> STEP, step counter loaded with i_step_count (0 treated as 1); STOP cmd ignored; CLEAR -> IDLE, cycle count zeroed.
REQ-006 RUN: o_pipeline_enable=1 each cycle unless a stop condition is true that cycle.
REQ-007 STEP: o_pipeline_enable=1 each cycle unless a stop condition is true; counter decrements per enabled cycle; enabled cycle with counter=1 -> PAUSED, cause 1.
REQ-008 Stop conditions (combinational, same cycle, enable forced 0): i_hlt -> HALTED cause 4; enabled breakpoint entry equal to i_pc -> PAUSED cause 2, o_bkpt_idx = lowest matching index; STOP cmd -> PAUSED cause 3.
REQ-009 Priority on simultaneous events: hlt > breakpoint > STOP > step exhaustion.
REQ-010 Breakpoint matches SHALL be masked during the first cycle after entering RUN or STEP, so resuming from a breakpoint PC advances.
REQ-011 HALTED SHALL be sticky: only CLEAR (-> IDLE, cause 0, cycle count 0) or reset exits; RUN/STEP/STOP ignored.
REQ-012 Commands in RUN/STEP other than STOP SHALL be ignored.
REQ-013 o_cycle_count SHALL increment on every cycle o_pipeline_enable=1 and saturate at all-ones.
REQ-014 o_done SHALL be registered, high exactly one cycle after the transition edge into PAUSED/HALTED; o_stop_cause and o_bkpt_idx update on that edge and hold until next stop or CLEAR; o_stop_cause reads 0 while RUN/STEP.
REQ-015 Breakpoint table writes SHALL take effect next cycle; a match in the write cycle uses old contents; writes allowed in any state.
REQ-016 o_busy SHALL equal o_state[1] | o_state[2].

Reset
REQ-017 i_reset high SHALL asynchronously force IDLE (o_state=5'b00001), all breakpoint entries disabled with address 0, step counter 0, o_cycle_count 0, o_stop_cause 0, o_bkpt_idx 0, o_done 0, o_pipeline_enable 0, o_busy 0.
REQ-018 Reset asserted mid-RUN/STEP SHALL drop o_pipeline_enable in the same cycle without waiting for a clock edge.

Verification
REQ-019 STEP count 3 from IDLE -> enable high exactly 3 cycles, o_done pulse, cause 1, PAUSED, o_cycle_count 3.
REQ-020 Bkpt entry 2 = 0x10 enabled, RUN, i_pc reaches 0x10 -> enable 0 that cycle, PAUSED, cause 2, o_bkpt_idx 2; RUN again with i_pc still 0x10 -> enable 1 first cycle (masked).
REQ-021 RUN then i_hlt and matching breakpoint same cycle -> HALTED, cause 4; subsequent RUN ignored; CLEAR -> IDLE, count 0.
REQ-022 STEP count 0 -> exactly 1 enabled cycle; STEP 5 with STOP on 2nd cycle -> 1 enabled cycle, cause 3.
REQ-023 DWORD=4, RUN 20 cycles -> o_cycle_count saturates at 4'hF.
REQ-024 Reset asserted between clock edges during RUN -> all outputs at reset values immediately, o_state 5'b00001.
